// File: rtl/busctl_pkg.sv
// Shared system-bus control definitions: bus source selects, fetch state encoding, bus width.
package busctl_pkg;

  localparam int BUS_W = 38;

  localparam logic [3:0] SEL_PC   = 4'd0;
  localparam logic [3:0] SEL_DR   = 4'd1;
  localparam logic [3:0] SEL_AR   = 4'd2;
  localparam logic [3:0] SEL_AC   = 4'd3;
  localparam logic [3:0] SEL_MEM  = 4'd4;
  localparam logic [3:0] SEL_TR   = 4'd5;
  localparam logic [3:0] SEL_ROP1 = 4'd6;
  localparam logic [3:0] SEL_ROP2 = 4'd7;
  localparam logic [3:0] SEL_GPR1 = 4'd8;
  localparam logic [3:0] SEL_NONE = 4'd9;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T0   = 3'd1,
    T1   = 3'd2,
    T2   = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } fetch_state_e;

endpackage

// File: rtl/fetch_wait_cnt.sv
// Memory wait-state counter for the fetch sequencer; term flags count == WAIT_MAX.
module fetch_wait_cnt #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             term
);

  always_ff @(posedge clk) begin
    if (rst || clr) count <= '0;
    else if (en)    count <= count + 1'b1;
  end

  assign term = (count == CNT_W'(WAIT_MAX));

endmodule

// File: rtl/bus_fetch_seq.sv
// Instruction fetch sequencer: PC->AR, MEM->DR (with wait states), DR->IR.
// Optional timeout to ERR enabled by macro FETCH_TIMEOUT_EN.
module bus_fetch_seq
  import busctl_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       flush,
  input  logic       mem_ready,
  output logic [3:0] sel,
  output logic       ld_ar,
  output logic       ld_dr,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       mem_rd,
  output logic       busy,
  output logic       done,
  output logic       err
);

  fetch_state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst)        state_q <= IDLE;
    else if (flush) state_q <= IDLE;
    else            state_q <= state_d;
  end

`ifdef FETCH_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt;
  logic             tmo;

  // Held clear outside T1 so the count always starts at zero on T1 entry.
  fetch_wait_cnt #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) u_wait (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q != T1),
    .en   ((state_q == T1) && !mem_ready),
    .count(wait_cnt),
    .term (tmo)
  );
`endif

  always_comb begin
    state_d = state_q;
    sel     = SEL_NONE;
    ld_ar   = 1'b0;
    ld_dr   = 1'b0;
    ld_ir   = 1'b0;
    inc_pc  = 1'b0;
    mem_rd  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = T0;
      T0: begin
        sel     = SEL_PC;
        ld_ar   = 1'b1;
        busy    = 1'b1;
        state_d = T1;
      end
      T1: begin
        sel    = SEL_MEM;
        mem_rd = 1'b1;
        busy   = 1'b1;
        if (mem_ready) begin
          // Data capture is suppressed when the cycle is being aborted.
          ld_dr   = !flush && !rst;
          inc_pc  = !flush && !rst;
          state_d = T2;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (tmo) state_d = ERR;
`endif
      end
      T2: begin
        sel     = SEL_DR;
        ld_ir   = 1'b1;
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
`ifdef FETCH_TIMEOUT_EN
        busy = 1'b1;
        err  = 1'b1;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_fetch_seq.sv
// Directed scoreboard bench for bus_fetch_seq; timeout checks apply when FETCH_TIMEOUT_EN is defined.
module tb_bus_fetch_seq;

  logic       clk = 1'b0;
  logic       rst, start, flush, mem_ready;
  logic [3:0] sel;
  logic       ld_ar, ld_dr, ld_ir, inc_pc, mem_rd, busy, done, err;

  int n_cmp = 0;
  int n_err = 0;
  logic [11:0] exp_q[$];

`ifdef FETCH_TIMEOUT_EN
  localparam int WMAX = 3;
`else
  localparam int WMAX = 15;
`endif

  bus_fetch_seq #(.WAIT_MAX(WMAX), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .mem_ready(mem_ready),
    .sel(sel), .ld_ar(ld_ar), .ld_dr(ld_dr), .ld_ir(ld_ir), .inc_pc(inc_pc),
    .mem_rd(mem_rd), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // {sel, ld_ar, ld_dr, ld_ir, inc_pc, mem_rd, busy, done, err}
  function automatic logic [11:0] mk(input logic [3:0] s, input logic ar, dr, ir, pc, rd, bz, dn, er);
    return {s, ar, dr, ir, pc, rd, bz, dn, er};
  endfunction

  logic [11:0] O_IDLE, O_T0, O_T1W, O_T1R, O_T2, O_DN, O_ER;

  // One cycle: expectation queued with the stimulus, popped when sampled mid-cycle.
  task automatic cyc(input logic [11:0] e, input string tag);
    logic [11:0] got, want;
    exp_q.push_back(e);
    @(negedge clk);
    got  = {sel, ld_ar, ld_dr, ld_ir, inc_pc, mem_rd, busy, done, err};
    want = exp_q.pop_front();
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    O_IDLE = mk(4'd9, 0, 0, 0, 0, 0, 0, 0, 0);
    O_T0   = mk(4'd0, 1, 0, 0, 0, 0, 1, 0, 0);
    O_T1W  = mk(4'd4, 0, 0, 0, 0, 1, 1, 0, 0);
    O_T1R  = mk(4'd4, 0, 1, 0, 1, 1, 1, 0, 0);
    O_T2   = mk(4'd1, 0, 0, 1, 0, 0, 1, 0, 0);
    O_DN   = mk(4'd9, 0, 0, 0, 0, 0, 1, 1, 0);
    O_ER   = mk(4'd9, 0, 0, 0, 0, 0, 1, 0, 1);

    rst = 1'b1; start = 1'b1; flush = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    cyc(O_IDLE, "rst0");
    cyc(O_IDLE, "rst1");
    rst = 1'b0; start = 1'b0;
    cyc(O_IDLE, "idle");

    // zero-wait fetch
    start = 1'b1; mem_ready = 1'b1;
    cyc(O_IDLE, "zw_acc");
    start = 1'b0;
    cyc(O_T0,   "zw_t0");
    cyc(O_T1R,  "zw_t1");
    cyc(O_T2,   "zw_t2");
    cyc(O_DN,   "zw_done");
    cyc(O_IDLE, "zw_idle");

    // three wait states
    start = 1'b1; mem_ready = 1'b0;
    cyc(O_IDLE, "ws_acc");
    start = 1'b0;
    cyc(O_T0, "ws_t0");
    for (int i = 0; i < 3; i++) cyc(O_T1W, "ws_wait");
    mem_ready = 1'b1;
    cyc(O_T1R, "ws_rdy");
    mem_ready = 1'b0;
    cyc(O_T2,   "ws_t2");
    cyc(O_DN,   "ws_done");
    cyc(O_IDLE, "ws_idle");

    // stuck memory
    start = 1'b1;
    cyc(O_IDLE, "to_acc");
    start = 1'b0;
    cyc(O_T0, "to_t0");
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 4; i++) cyc(O_T1W, "to_wait");
    cyc(O_ER,   "to_err");
    cyc(O_IDLE, "to_idle");
`else
    for (int i = 0; i < 20; i++) cyc(O_T1W, "nto_wait");
    mem_ready = 1'b1;
    cyc(O_T1R, "nto_rdy");
    mem_ready = 1'b0;
    cyc(O_T2,   "nto_t2");
    cyc(O_DN,   "nto_done");
    cyc(O_IDLE, "nto_idle");
`endif

    // flush in T1 together with mem_ready and start
    start = 1'b1;
    cyc(O_IDLE, "fl_acc");
    start = 1'b0;
    cyc(O_T0,  "fl_t0");
    cyc(O_T1W, "fl_t1");
    flush = 1'b1; mem_ready = 1'b1; start = 1'b1;
    cyc(O_T1W, "fl_nold");
    flush = 1'b0; mem_ready = 1'b0; start = 1'b0;
    cyc(O_IDLE, "fl_idle");
    cyc(O_IDLE, "fl_idle2");

    // start held high: back-to-back fetches
    start = 1'b1; mem_ready = 1'b1;
    cyc(O_IDLE, "bb_acc");
    cyc(O_T0,   "bb_t0a");
    cyc(O_T1R,  "bb_t1a");
    cyc(O_T2,   "bb_t2a");
    cyc(O_DN,   "bb_dna");
    cyc(O_IDLE, "bb_idle");
    cyc(O_T0,   "bb_t0b");
    start = 1'b0;
    cyc(O_T1R,  "bb_t1b");
    cyc(O_T2,   "bb_t2b");
    cyc(O_DN,   "bb_dnb");
    cyc(O_IDLE, "bb_end");

    // start pulse during T1 ignored
    start = 1'b1; mem_ready = 1'b0;
    cyc(O_IDLE, "ig_acc");
    start = 1'b0;
    cyc(O_T0, "ig_t0");
    start = 1'b1;
    cyc(O_T1W, "ig_t1");
    start = 1'b0; mem_ready = 1'b1;
    cyc(O_T1R,  "ig_rdy");
    cyc(O_T2,   "ig_t2");
    cyc(O_DN,   "ig_done");
    cyc(O_IDLE, "ig_idle");
    cyc(O_IDLE, "ig_noq");

    // reset mid-fetch beats flush/start/mem_ready
    start = 1'b1; mem_ready = 1'b0;
    cyc(O_IDLE, "rm_acc");
    start = 1'b0;
    cyc(O_T0, "rm_t0");
    rst = 1'b1; flush = 1'b1; start = 1'b1; mem_ready = 1'b1;
    cyc(O_T1W, "rm_t1");
    cyc(O_IDLE, "rm_rst");
    rst = 1'b0; flush = 1'b0; start = 1'b0; mem_ready = 1'b0;
    cyc(O_IDLE, "rm_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
